// File: rtl/clock_gate_enable_ctrl.sv
// Clock-gate enable controller: drives a domain gater EN from the ungated side.
// Detects sustained idleness, runs a quiesce req/ack handshake, and re-enables on wake.
//
// Ports:
//   i_clkin      free-running clock (ungated side of the gater)
//   i_rst        synchronous reset, active-high
//   i_active     domain has pending/in-flight work
//   i_wake       external wake request (level)
//   i_disable    force clock on; gating inhibited
//   i_qack       domain accepts quiesce (safe to stop clock)
//   o_en         gater EN; 1 = clock running
//   o_qreq       quiesce request to the domain
//   o_ready      domain clock running and settled
//   o_state      encoded FSM state (debug)
//   o_gated_cnt  saturating count of entries to GATED
module clock_gate_enable_ctrl #(
    parameter int IDLE_CYCLES   = 16,
    parameter int WAKE_CYCLES   = 2,
    parameter int MIN_ON_CYCLES = 8,
    parameter int TMR_W         = 8,
    parameter int CNT_W         = 16
) (
    input  logic             i_clkin,
    input  logic             i_rst,
    input  logic             i_active,
    input  logic             i_wake,
    input  logic             i_disable,
    input  logic             i_qack,
    output logic             o_en,
    output logic             o_qreq,
    output logic             o_ready,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_gated_cnt
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_IDLE    = 3'd1,
        S_QUIESCE = 3'd2,
        S_GATED   = 3'd3,
        S_WAKE    = 3'd4
    } state_t;

    localparam logic [TMR_W-1:0] L_MIN     = TMR_W'(MIN_ON_CYCLES);
    localparam logic [TMR_W-1:0] L_IDLE_M1 = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] L_WAKE_M1 = TMR_W'(WAKE_CYCLES - 1);
    localparam logic [TMR_W-1:0] L_T_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] L_C_ONE   = CNT_W'(1);

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic               r_en;
    logic               r_qreq;
    logic               r_ready;
    logic [CNT_W-1:0]   r_gated_cnt;

    state_t             w_state_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               w_gate_ev;
    logic               w_wake_ev;
    logic               w_min_met;
    logic               w_en_nxt;
    logic               w_qreq_nxt;
    logic               w_ready_nxt;

    assign w_wake_ev = i_active | i_wake | i_disable;

    // The current RUN cycle completes the min-on window when timer+1 >= MIN.
    // Widened by one bit so MIN_ON_CYCLES=0 is always met.
    assign w_min_met = ({1'b0, r_timer} + (TMR_W + 1)'(1)) >= {1'b0, L_MIN};

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_gate_ev   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_min_met && !w_wake_ev && !i_qack) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer < L_MIN) begin
                    w_timer_nxt = r_timer + L_T_ONE;
                end
            end
            S_IDLE: begin
                if (w_wake_ev) begin
                    // Return with min-on already satisfied.
                    w_state_nxt = S_RUN;
                    w_timer_nxt = L_MIN;
                end else if (r_timer == L_IDLE_M1) begin
                    // QREQ may only rise while QACK is low; otherwise wait here.
                    if (!i_qack) begin
                        w_state_nxt = S_QUIESCE;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer + L_T_ONE;
                end
            end
            S_QUIESCE: begin
                if (w_wake_ev) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = L_MIN;
                end else if (i_qack) begin
                    w_state_nxt = S_GATED;
                    w_gate_ev   = 1'b1;
                end
            end
            S_GATED: begin
                if (w_wake_ev) begin
                    w_state_nxt = S_WAKE;
                    w_timer_nxt = '0;
                end
            end
            S_WAKE: begin
                if (r_timer == L_WAKE_M1) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + L_T_ONE;
                end
            end
            default: begin
                w_state_nxt = S_WAKE;
                w_timer_nxt = '0;
            end
        endcase

        w_en_nxt    = (w_state_nxt != S_GATED);
        w_qreq_nxt  = (w_state_nxt == S_QUIESCE) ||
                      (w_state_nxt == S_GATED);
        w_ready_nxt = (w_state_nxt == S_RUN) ||
                      (w_state_nxt == S_IDLE) ||
                      (w_state_nxt == S_QUIESCE);
    end

    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_state     <= S_WAKE;
            r_timer     <= '0;
            r_en        <= 1'b1;
            r_qreq      <= 1'b0;
            r_ready     <= 1'b0;
            r_gated_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_en    <= w_en_nxt;
            r_qreq  <= w_qreq_nxt;
            r_ready <= w_ready_nxt;
            if (w_gate_ev && (r_gated_cnt != {CNT_W{1'b1}})) begin
                r_gated_cnt <= r_gated_cnt + L_C_ONE;
            end
        end
    end

    assign o_en        = r_en;
    assign o_qreq      = r_qreq;
    assign o_ready     = r_ready;
    assign o_state     = r_state;
    assign o_gated_cnt = r_gated_cnt;

endmodule

// File: tb/tb_clock_gate_enable_ctrl.sv
// Testbench for clock_gate_enable_ctrl: directed handshake, wake, disable and reset steps.
// A second instance with a 2-bit counter shares the stimulus to show saturation.
module tb_clock_gate_enable_ctrl;

    localparam int SEL_EN    = 0;
    localparam int SEL_QREQ  = 1;
    localparam int SEL_READY = 2;
    localparam int SEL_STATE = 3;
    localparam int SEL_CNT   = 4;
    localparam int SEL_CNT2  = 5;
    localparam int SEL_STAT2 = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        active;
    logic        wake;
    logic        dis;
    logic        qack;
    logic        en, qreq, ready;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic        en2, qreq2, ready2;
    logic [2:0]  state2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clock_gate_enable_ctrl dut (
        .i_clkin(clk), .i_rst(rst), .i_active(active), .i_wake(wake),
        .i_disable(dis), .i_qack(qack), .o_en(en), .o_qreq(qreq),
        .o_ready(ready), .o_state(state), .o_gated_cnt(cnt)
    );

    clock_gate_enable_ctrl #(.CNT_W(2)) dut2 (
        .i_clkin(clk), .i_rst(rst), .i_active(active), .i_wake(wake),
        .i_disable(dis), .i_qack(qack), .o_en(en2), .o_qreq(qreq2),
        .o_ready(ready2), .o_state(state2), .o_gated_cnt(cnt2)
    );

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_EN:    return {15'd0, en};
            SEL_QREQ:  return {15'd0, qreq};
            SEL_READY: return {15'd0, ready};
            SEL_STATE: return {13'd0, state};
            SEL_CNT:   return cnt;
            SEL_CNT2:  return {14'd0, cnt2};
            SEL_STAT2: return {13'd0, state2};
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Counts cycles until QREQ is seen; also reports any EN drop meanwhile.
    task automatic wait_qreq(input int max, output int n, output int drops);
        n = 0;
        drops = 0;
        while (!qreq && n < max) begin
            tick();
            n++;
            if (!en) drops++;
        end
    endtask

    task automatic gate_once(input int k);
        int n, d;
        wait_qreq(100, n, d);
        chk($sformatf("qreq_seen_%0d", k), int'(qreq), 1);
        qack = 1'b1;
        tick();
        qack = 1'b0;
        push($sformatf("gate%0d_en", k), SEL_EN, 16'd0);
        push($sformatf("gate%0d_cnt", k), SEL_CNT, 16'(k));
        push($sformatf("gate%0d_cnt2", k), SEL_CNT2, 16'(k > 3 ? 3 : k));
        drain();
    endtask

    initial begin
        int n, d;
        rst = 1'b1;
        active = 1'b0;
        wake = 1'b0;
        dis = 1'b0;
        qack = 1'b0;

        tick();
        push("rst_state", SEL_STATE, 16'd4);
        push("rst_en", SEL_EN, 16'd1);
        push("rst_qreq", SEL_QREQ, 16'd0);
        push("rst_ready", SEL_READY, 16'd0);
        push("rst_cnt", SEL_CNT, 16'd0);
        drain();
        rst = 1'b0;

        tick();
        push("wake1_ready", SEL_READY, 16'd0);
        push("wake1_en", SEL_EN, 16'd1);
        drain();
        tick();
        push("wake2_ready", SEL_READY, 16'd1);
        push("wake2_state", SEL_STATE, 16'd0);
        drain();

        wait_qreq(100, n, d);
        chk("ready_to_qreq", n, 24);
        chk("en_drops_t1", d, 0);
        push("t1_state", SEL_STATE, 16'd2);
        push("t1_en", SEL_EN, 16'd1);
        drain();

        qack = 1'b1;
        tick();
        qack = 1'b0;
        push("t2_en", SEL_EN, 16'd0);
        push("t2_ready", SEL_READY, 16'd0);
        push("t2_qreq", SEL_QREQ, 16'd1);
        push("t2_state", SEL_STATE, 16'd3);
        push("t2_cnt", SEL_CNT, 16'd1);
        drain();

        wake = 1'b1;
        tick();
        wake = 1'b0;
        push("t2_wake_en", SEL_EN, 16'd1);
        push("t2_wake_qreq", SEL_QREQ, 16'd0);
        push("t2_wake_ready", SEL_READY, 16'd0);
        push("t2_wake_state", SEL_STATE, 16'd4);
        drain();
        tick();
        push("t2_ready_p2", SEL_READY, 16'd0);
        drain();
        tick();
        push("t2_ready_p3", SEL_READY, 16'd1);
        drain();

        wait_qreq(100, n, d);
        chk("t3_reach_quiesce", n, 24);
        active = 1'b1;
        qack = 1'b1;
        tick();
        active = 1'b0;
        qack = 1'b0;
        push("t3_qreq", SEL_QREQ, 16'd0);
        push("t3_en", SEL_EN, 16'd1);
        push("t3_state", SEL_STATE, 16'd0);
        push("t3_cnt", SEL_CNT, 16'd1);
        drain();

        d = 0;
        repeat (16) begin
            tick();
            if (qreq) d++;
        end
        chk("t4_no_early_qreq", d, 0);
        active = 1'b1;
        tick();
        active = 1'b0;
        push("t4_pulse_qreq", SEL_QREQ, 16'd0);
        push("t4_pulse_state", SEL_STATE, 16'd0);
        drain();
        wait_qreq(100, n, d);
        chk("t4_pulse_to_qreq", n, 17);

        qack = 1'b1;
        tick();
        qack = 1'b0;
        push("t5_gated_en", SEL_EN, 16'd0);
        push("t5_cnt", SEL_CNT, 16'd2);
        drain();
        dis = 1'b1;
        tick();
        push("t5_dis_en", SEL_EN, 16'd1);
        push("t5_dis_qreq", SEL_QREQ, 16'd0);
        drain();
        n = 0;
        d = 0;
        repeat (1000) begin
            tick();
            if (qreq) n++;
            if (!en) d++;
        end
        chk("t5_qreq_while_dis", n, 0);
        chk("t5_en_low_while_dis", d, 0);
        push("t5_ready", SEL_READY, 16'd1);
        drain();
        dis = 1'b0;

        for (int k = 3; k <= 5; k++) begin
            gate_once(k);
            if (k < 5) begin
                wake = 1'b1;
                tick();
                wake = 1'b0;
            end
        end
        push("t6_pre_state", SEL_STATE, 16'd3);
        push("t6_pre_state2", SEL_STAT2, 16'd3);
        drain();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        push("t6_rst_en", SEL_EN, 16'd1);
        push("t6_rst_ready", SEL_READY, 16'd0);
        push("t6_rst_qreq", SEL_QREQ, 16'd0);
        push("t6_rst_cnt", SEL_CNT, 16'd0);
        push("t6_rst_cnt2", SEL_CNT2, 16'd0);
        push("t6_rst_state", SEL_STATE, 16'd4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
